mod_n_bcd_counter: RTL

//   Parametrised multi-digit BCD modulo-N counter for the digital clock (seconds/minutes = 60, hours = 24/12).
//   Run mode: counts tick enables and emits a one-cycle carry to the next stage.
//   Set mode: ignores ticks; debounced-level buttons step the value up/down with wrap.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/bcd_digit_cell.sv | 31 +++
 rtl/mod_n_bcd_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants and helpers for the digital-clock BCD counters.
package clock_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 4;

  // Packed BCD of v, LSD at [3:0]; digits above 'digits' are left zero.
  function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int v, input int digits);
    logic [BCD_W*MAX_DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      if (k < digits) r[BCD_W*k +: BCD_W] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit: clear/load/increment/decrement with ripple carry and borrow.
module bcd_digit_cell
  import clock_pkg::*;
#(
  parameter logic [BCD_W-1:0] RESET_DIGIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  output logic [BCD_W-1:0] digit,
  output logic             carry_out,
  output logic             borrow_out
);

  assign carry_out  = inc && (digit == 4'd9);
  assign borrow_out = dec && (digit == 4'd0);

  // Non-BCD codes step back into 0..9 rather than propagating garbage.
  always_ff @(posedge clk) begin
    if (!rst_n)     digit <= RESET_DIGIT;
    else if (clear) digit <= '0;
    else if (load)  digit <= load_val;
    else if (inc)   digit <= (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    else if (dec)   digit <= (digit == 4'd0 || digit > 4'd9) ? 4'd9 : digit - 4'd1;
  end

endmodule

// File: rtl/mod_n_bcd_counter.sv
// Multi-digit BCD modulo-N counter: tick-driven run mode, button-driven set mode.
module mod_n_bcd_counter
  import clock_pkg::*;
#(
  parameter int MOD_N       = 60,
  parameter int DIGITS      = 2,
  parameter int RESET_VALUE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick_en,
  input  logic                set_mode,
  input  logic                up_n,
  input  logic                down_n,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tc,
  output logic                carry_out
);

  localparam int W = BCD_W * DIGITS;
  localparam logic [BCD_W*MAX_DIGITS-1:0] TOP_FULL = to_bcd(MOD_N - 1, DIGITS);
  localparam logic [BCD_W*MAX_DIGITS-1:0] RST_FULL = to_bcd(RESET_VALUE, DIGITS);
  localparam logic [W-1:0] TOP_BCD = TOP_FULL[W-1:0];

  logic [2:0]  up_sync, down_sync;
  logic        up_p, down_p;
  logic        inc_en, dec_en, clr_all, load_top, carry_d;
  logic        bad_digit, at_top, at_zero, wrap_hi;
  logic [DIGITS:0] inc_c, dec_c;
  logic [W-1:0] value;

  // [0],[1] synchronise; [2] is the previous sample for falling-edge detect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      up_sync   <= 3'b111;
      down_sync <= 3'b111;
      up_p      <= 1'b0;
      down_p    <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      up_sync   <= {up_sync[1:0], up_n};
      down_sync <= {down_sync[1:0], down_n};
      up_p      <= up_sync[2] & ~up_sync[1];
      down_p    <= down_sync[2] & ~down_sync[1];
      carry_out <= carry_d;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (value[BCD_W*k +: BCD_W] > 4'd9) bad_digit = 1'b1;
  end

  assign at_top  = (value == TOP_BCD);
  assign at_zero = (value == '0);
  // With valid digits the BCD vector orders like the number it encodes.
  assign wrap_hi = at_top || bad_digit || (value > TOP_BCD);

  always_comb begin
    inc_en   = 1'b0;
    dec_en   = 1'b0;
    clr_all  = 1'b0;
    load_top = 1'b0;
    carry_d  = 1'b0;
    if (!set_mode) begin
      if (tick_en) begin
        if (wrap_hi) begin
          clr_all = 1'b1;
          carry_d = at_top;
        end else begin
          inc_en = 1'b1;
        end
      end
    end else if (up_p && !down_p) begin
      if (wrap_hi) clr_all = 1'b1;
      else         inc_en  = 1'b1;
    end else if (down_p && !up_p) begin
      if (at_zero || bad_digit || value > TOP_BCD) load_top = 1'b1;
      else                                         dec_en   = 1'b1;
    end
  end

  assign inc_c[0] = inc_en;
  assign dec_c[0] = dec_en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell #(
      .RESET_DIGIT(RST_FULL[BCD_W*k +: BCD_W])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_c[k]),
      .dec       (dec_c[k]),
      .clear     (clr_all),
      .load      (load_top),
      .load_val  (TOP_BCD[BCD_W*k +: BCD_W]),
      .digit     (value[BCD_W*k +: BCD_W]),
      .carry_out (inc_c[k+1]),
      .borrow_out(dec_c[k+1])
    );
  end

  assign bcd_out = value;
  assign tc      = at_top;

endmodule
